// File: rtl/array_heap_engine_if.sv
// Command/response bus for array_heap_engine: valid/ready command channel
// plus a single-cycle response strobe with data and error code.
interface array_heap_engine_if #(
    parameter int MemoryElementWidth = 12
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [2:0]                    cmd_op;
    logic [MemoryElementWidth-1:0] cmd_array;
    logic [MemoryElementWidth-1:0] cmd_index;
    logic [MemoryElementWidth-1:0] cmd_data;
    logic                          rsp_valid;
    logic [MemoryElementWidth-1:0] rsp_data;
    logic [2:0]                    rsp_error;

    modport master (
        output cmd_valid, cmd_op, cmd_array, cmd_index, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_array, cmd_index, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_error
    );
endinterface

// File: rtl/array_heap_engine.sv
// Dynamic-array engine: NArrays fixed areas of NArea elements in one heap, IDLE/EXEC/RESP command FSM.
// Optional ARRAY_HEAP_STATS_EN adds stat_peak (in_use high-water) and stat_errors (saturating).
module array_heap_engine #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 8,
    parameter int NArrays            = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    array_heap_engine_if.slave            bus,
    output logic [MemoryElementWidth-1:0] in_use
`ifdef ARRAY_HEAP_STATS_EN
    ,
    output logic [MemoryElementWidth-1:0] stat_peak,
    output logic [15:0]                   stat_errors
`endif
);
    localparam int MEW   = MemoryElementWidth;
    localparam int HW    = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int CW    = $clog2(NArrays + 1);
    localparam int DEPTH = NArrays * NArea;
    localparam int HAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW    = $clog2(DEPTH) + 1;

    localparam logic [MEW-1:0] NARR_W  = MEW'(NArrays);
    localparam logic [MEW-1:0] NAREA_W = MEW'(NArea);
    localparam logic [CW-1:0]  NARR_C  = CW'(NArrays);
    localparam logic [AW-1:0]  NAREA_A = AW'(NArea);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
    typedef enum logic [2:0] {
        OP_ALLOC = 3'd0, OP_FREE = 3'd1, OP_PUSH = 3'd2, OP_POP = 3'd3,
        OP_READ  = 3'd4, OP_WRITE = 3'd5, OP_SIZE = 3'd6, OP_RSVD = 3'd7
    } op_t;
    typedef enum logic [2:0] {
        E_OK = 3'd0, E_OVER = 3'd1, E_UNDER = 3'd2, E_NOFREE = 3'd3,
        E_HANDLE = 3'd4, E_RANGE = 3'd5, E_BADOP = 3'd6
    } err_t;

    state_t          r_state, w_next;
    op_t             r_cmd_op;
    logic [MEW-1:0]  r_cmd_array, r_cmd_index, r_cmd_data;
    logic [MEW-1:0]  r_rsp_data;
    err_t            r_rsp_error;
    logic [MEW-1:0]  r_in_use;
    logic [CW-1:0]   r_allocs, r_free_top;
    logic [HW-1:0]   r_free_stk [NArrays];
    logic [NArrays-1:0] r_alloc_bits;
    logic [MEW-1:0]  r_size [NArrays];
    logic [MEW-1:0]  r_heap [DEPTH];

    logic [HW-1:0]   w_hidx, w_alloc_h;
    logic            w_hok;
    logic [MEW-1:0]  w_size, w_new_size, w_rsp_data, w_rd_data;
    logic [AW-1:0]   w_base, w_rd_addr, w_wr_addr;
    err_t            w_err;

    assign w_hidx    = r_cmd_array[HW-1:0];
    assign w_hok     = (r_cmd_array < NARR_W) && r_alloc_bits[w_hidx];
    assign w_size    = r_size[w_hidx];
    assign w_base    = AW'(w_hidx) * NAREA_A;
    assign w_rd_data = r_heap[HAW'(w_rd_addr)];

    // Addresses only matter once the range checks below have passed.
    always_comb begin
        w_rd_addr = w_base + AW'(r_cmd_index);
        w_wr_addr = w_base + AW'(w_size);
        if (r_cmd_op == OP_POP && w_size != '0)
            w_rd_addr = w_base + AW'(w_size - 1'b1);
        if (r_cmd_op == OP_WRITE)
            w_wr_addr = w_base + AW'(r_cmd_index);
    end

    always_comb begin
        w_err      = E_OK;
        w_rsp_data = '0;
        w_alloc_h  = '0;
        w_new_size = w_size;
        if (r_cmd_op == OP_RSVD) begin
            w_err = E_BADOP;
        end else if (r_cmd_op == OP_ALLOC) begin
            w_new_size = '0;
            if (r_free_top != '0)
                w_alloc_h = r_free_stk[HW'(r_free_top - 1'b1)];
            else if (r_allocs < NARR_C)
                w_alloc_h = HW'(r_allocs);
            else
                w_err = E_NOFREE;
            w_rsp_data = MEW'(w_alloc_h);
        end else if (!w_hok) begin
            w_err = E_HANDLE;
        end else begin
            case (r_cmd_op)
                OP_PUSH: begin
                    if (w_size == NAREA_W) w_err = E_OVER;
                    else begin
                        w_new_size = w_size + 1'b1;
                        w_rsp_data = w_new_size;
                    end
                end
                OP_POP: begin
                    if (w_size == '0) w_err = E_UNDER;
                    else begin
                        w_new_size = w_size - 1'b1;
                        w_rsp_data = w_rd_data;
                    end
                end
                OP_READ: begin
                    if (r_cmd_index >= w_size) w_err = E_RANGE;
                    else w_rsp_data = w_rd_data;
                end
                OP_WRITE: begin
                    if (r_cmd_index >= NAREA_W) w_err = E_RANGE;
                    else begin
                        if (r_cmd_index >= w_size) w_new_size = r_cmd_index + 1'b1;
                        w_rsp_data = w_new_size;
                    end
                end
                OP_SIZE: w_rsp_data = w_size;
                default: w_rsp_data = '0;
            endcase
        end
        if (w_err != E_OK) w_rsp_data = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.cmd_valid) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (r_state == S_IDLE);
        bus.rsp_valid = (r_state == S_RESP);
        bus.rsp_data  = r_rsp_data;
        bus.rsp_error = r_rsp_error;
        in_use        = r_in_use;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_op     <= OP_ALLOC;
            r_cmd_array  <= '0;
            r_cmd_index  <= '0;
            r_cmd_data   <= '0;
            r_rsp_data   <= '0;
            r_rsp_error  <= E_OK;
            r_in_use     <= '0;
            r_allocs     <= '0;
            r_free_top   <= '0;
            r_alloc_bits <= '0;
            for (int unsigned i = 0; i < NArrays; i++) begin
                r_size[i]     <= '0;
                r_free_stk[i] <= '0;
            end
        end else if (r_state == S_IDLE) begin
            if (bus.cmd_valid) begin
                r_cmd_op    <= op_t'(bus.cmd_op);
                r_cmd_array <= bus.cmd_array;
                r_cmd_index <= bus.cmd_index;
                r_cmd_data  <= bus.cmd_data;
            end
        end else if (r_state == S_EXEC) begin
            r_rsp_data  <= w_rsp_data;
            r_rsp_error <= w_err;
            if (w_err == E_OK) begin
                case (r_cmd_op)
                    OP_ALLOC: begin
                        if (r_free_top != '0) r_free_top <= r_free_top - 1'b1;
                        else                  r_allocs   <= r_allocs + 1'b1;
                        r_alloc_bits[w_alloc_h] <= 1'b1;
                        r_size[w_alloc_h]       <= '0;
                        r_in_use                <= r_in_use + 1'b1;
                    end
                    OP_FREE: begin
                        r_alloc_bits[w_hidx]          <= 1'b0;
                        r_free_stk[HW'(r_free_top)]   <= w_hidx;
                        r_free_top                    <= r_free_top + 1'b1;
                        r_in_use                      <= r_in_use - 1'b1;
                    end
                    OP_PUSH, OP_POP, OP_WRITE: r_size[w_hidx] <= w_new_size;
                    default: ;
                endcase
            end
        end
    end

    // Heap storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (r_state == S_EXEC && w_err == E_OK &&
            (r_cmd_op == OP_PUSH || r_cmd_op == OP_WRITE))
            r_heap[HAW'(w_wr_addr)] <= r_cmd_data;
    end

`ifdef ARRAY_HEAP_STATS_EN
    logic [MEW-1:0] r_stat_peak;
    logic [15:0]    r_stat_errors;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_peak   <= '0;
            r_stat_errors <= '0;
        end else if (r_state == S_RESP) begin
            if (r_in_use > r_stat_peak) r_stat_peak <= r_in_use;
            if (r_rsp_error != E_OK && r_stat_errors != '1)
                r_stat_errors <= r_stat_errors + 1'b1;
        end
    end

    assign stat_peak   = r_stat_peak;
    assign stat_errors = r_stat_errors;
`endif
endmodule

// File: tb/tb_array_heap_engine.sv
// Directed, table-driven bench for array_heap_engine plus hand sequences for reset and back-to-back timing.
module tb_array_heap_engine;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] in_use;
`ifdef ARRAY_HEAP_STATS_EN
    logic [W-1:0] stat_peak;
    logic [15:0]  stat_errors;
`endif

    array_heap_engine_if #(.MemoryElementWidth(W)) bus ();

    array_heap_engine #(
        .MemoryElementWidth(W),
        .NArea(8),
        .NArrays(4)
    ) dut (
        .clock(clk),
        .reset_n(rst_n),
        .bus(bus.slave),
        .in_use(in_use)
`ifdef ARRAY_HEAP_STATS_EN
        ,
        .stat_peak(stat_peak),
        .stat_errors(stat_errors)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] arr;
        logic [W-1:0] idx;
        logic [W-1:0] data;
        logic [W-1:0] exp_data;
        logic [2:0]   exp_err;
        logic [W-1:0] exp_inuse;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic addv(input int op, input int arr, input int idx, input int data,
                        input int ed, input int ee, input int eu);
        vec_t v;
        v.op = 3'(op); v.arr = W'(arr); v.idx = W'(idx); v.data = W'(data);
        v.exp_data = W'(ed); v.exp_err = 3'(ee); v.exp_inuse = W'(eu);
        vecs.push_back(v);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] arr, input logic [W-1:0] idx,
                          input logic [W-1:0] data, output logic [W-1:0] rd, output logic [2:0] re);
        int n;
        rd = '0;
        re = '0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_array = arr;
        bus.cmd_index = idx;
        bus.cmd_data  = data;
        n = 0;
        while (!bus.cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            chk("accept_timeout", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 8);
        chk("rsp_latency", 32'(n), 32'd2);
        rd = bus.rsp_data;
        re = bus.rsp_error;
        @(negedge clk);
        chk("rsp_pulse_then_ready", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [W-1:0] rd;
        logic [2:0]   re;
        int           exp_errs;
        int           n_rsp, n_low, n_pat;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_array = '0;
        bus.cmd_index = '0;
        bus.cmd_data  = '0;

        // op: 0 ALLOC 1 FREE 2 PUSH 3 POP 4 READ 5 WRITE 6 SIZE 7 reserved
        addv(0, 0, 0, 0,   0, 0, 1);
        addv(2, 0, 0, 1,   1, 0, 1);
        addv(2, 0, 0, 2,   2, 0, 1);
        addv(3, 0, 0, 0,   2, 0, 1);
        addv(3, 0, 0, 0,   1, 0, 1);
        addv(3, 0, 0, 0,   0, 2, 1);
        addv(6, 0, 0, 0,   0, 0, 1);
        addv(0, 0, 0, 0,   1, 0, 2);
        addv(0, 0, 0, 0,   2, 0, 3);
        addv(0, 0, 0, 0,   3, 0, 4);
        addv(0, 0, 0, 0,   0, 3, 4);
        addv(1, 2, 0, 0,   0, 0, 3);
        addv(0, 0, 0, 0,   2, 0, 4);
        for (int i = 0; i < 8; i++) addv(2, 3, 0, 10 + i, i + 1, 0, 4);
        addv(2, 3, 0, 18,  0, 1, 4);
        addv(4, 3, 7, 0,   17, 0, 4);
        addv(4, 3, 8, 0,   0, 5, 4);
        addv(6, 3, 0, 0,   8, 0, 4);
        addv(5, 2, 5, 9,   6, 0, 4);
        addv(4, 2, 5, 0,   9, 0, 4);
        addv(4, 2, 6, 0,   0, 5, 4);
        addv(6, 2, 0, 0,   6, 0, 4);
        addv(5, 2, 8, 50,  0, 5, 4);
        addv(6, 2, 0, 0,   6, 0, 4);
        addv(5, 2, 7, 33,  8, 0, 4);
        addv(4, 2, 7, 0,   33, 0, 4);
        addv(1, 1, 0, 0,   0, 0, 3);
        addv(1, 1, 0, 0,   0, 4, 3);
        addv(2, 9, 0, 5,   0, 4, 3);
        addv(7, 0, 0, 0,   0, 6, 3);
        addv(6, 4, 0, 0,   0, 4, 3);
        addv(6, 0, 0, 0,   0, 0, 3);
        addv(6, 3, 0, 0,   8, 0, 3);
        addv(3, 3, 0, 0,   17, 0, 3);
        addv(6, 3, 0, 0,   7, 0, 3);
        addv(0, 0, 0, 0,   1, 0, 4);
        addv(6, 1, 0, 0,   0, 0, 4);
        addv(4, 1, 0, 0,   0, 5, 4);

        #12;
        chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("reset_rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("reset_in_use",    32'(in_use),        32'd0);
`ifdef ARRAY_HEAP_STATS_EN
        chk("reset_stat_peak",   32'(stat_peak),   32'd0);
        chk("reset_stat_errors", 32'(stat_errors), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        exp_errs = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            do_cmd(vecs[i].op, vecs[i].arr, vecs[i].idx, vecs[i].data, rd, re);
            chk($sformatf("v%0d_op%0d_data", i, vecs[i].op), 32'(rd), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_op%0d_error", i, vecs[i].op), 32'(re), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_op%0d_in_use", i, vecs[i].op), 32'(in_use), 32'(vecs[i].exp_inuse));
            if (vecs[i].exp_err != 3'd0) exp_errs++;
        end
`ifdef ARRAY_HEAP_STATS_EN
        chk("stat_peak",   32'(stat_peak),   32'd4);
        chk("stat_errors", 32'(stat_errors), 32'(exp_errs));
`endif

        // Reset during the EXEC cycle of a PUSH.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd2;
        bus.cmd_array = '0;
        bus.cmd_index = '0;
        bus.cmd_data  = 12'd55;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("exec_before_reset_ready", 32'(bus.cmd_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midreset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midreset_in_use",    32'(in_use),        32'd0);
        chk("midreset_rsp_data",  32'(bus.rsp_data),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_rsp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rsp++;
        end
        chk("midreset_no_rsp", 32'(n_rsp), 32'd0);
        do_cmd(3'd6, 12'd0, 12'd0, 12'd0, rd, re);
        chk("post_reset_size_err", 32'(re), 32'd4);
        do_cmd(3'd0, 12'd0, 12'd0, 12'd0, rd, re);
        chk("post_reset_alloc_h", 32'(rd), 32'd0);
        chk("post_reset_in_use", 32'(in_use), 32'd1);
        do_cmd(3'd6, 12'd0, 12'd0, 12'd0, rd, re);
        chk("post_reset_size", 32'(rd), 32'd0);

        // Back-to-back: cmd_valid held high, engine should cycle IDLE/EXEC/RESP.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd6;
        bus.cmd_array = '0;
        n_rsp = 0; n_low = 0; n_pat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rsp++;
            if (!bus.cmd_ready) n_low++;
            if (bus.cmd_ready != (i % 3 == 0)) n_pat++;
        end
        bus.cmd_valid = 1'b0;
        chk("b2b_rsp_count", 32'(n_rsp), 32'd4);
        chk("b2b_ready_low_cycles", 32'(n_low), 32'd8);
        chk("b2b_ready_pattern_errs", 32'(n_pat), 32'd0);
        repeat (3) @(negedge clk);
        chk("b2b_idle_ready", 32'(bus.cmd_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/array_heap_engine.md
Name: array_heap_engine

Overview:
- Parametrised hardware engine for the dynamic arrays used by the test programs: allocate, free, push, pop, indexed read/write and size query.
- Multiple arrays live in one heap; each array owns a fixed area of NArea elements.
- Commands arrive over a valid/ready handshake. Each command returns exactly one response carrying data and an error code.
- Sits between the instruction sequencer and heap storage, replacing hand-inlined array code.

Parameters:
- MemoryElementWidth, 12, width of data, handle, index and size fields.
- NArea, 8, elements per array area (maximum array length).
- NArrays, 4, maximum simultaneously allocated arrays.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  engine can accept a command
- cmd_op  input  3  0=ALLOC 1=FREE 2=PUSH 3=POP 4=READ 5=WRITE 6=SIZE 7=reserved
- cmd_array  input  MemoryElementWidth  array handle
- cmd_index  input  MemoryElementWidth  element index (READ/WRITE)
- cmd_data  input  MemoryElementWidth  data (PUSH/WRITE)
- rsp_valid  output  1  one-cycle response strobe
- rsp_data  output  MemoryElementWidth  result: handle, element or size
- rsp_error  output  3  0=ok 1=overflow 2=underflow 3=no free array 4=bad handle 5=index range 6=bad op
- in_use  output  MemoryElementWidth  arrays currently allocated

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_error=0, in_use=0.
  - allocs=0, freed-stack top=0, all allocated bits=0, all sizes=0.
  - Heap contents are not cleared.
- States:
  - IDLE: cmd_ready=1. cmd_valid&&cmd_ready at a clock edge latches all cmd fields and moves to EXEC.
  - EXEC: cmd_ready=0. Performs the operation and moves to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Accept-to-rsp_valid latency is 2 cycles. One command is outstanding at most; the next can be accepted in the cycle after the rsp_valid cycle.
- rsp_data and rsp_error hold their value until the next response. rsp_data=0 whenever rsp_error!=0.
- Handle check: every op except ALLOC gives error 4 if cmd_array>=NArrays or the array is not allocated. A failed command changes no state.
- ALLOC:
  - If the freed stack is non-empty, pop its handle.
  - Else if allocs<NArrays, return allocs and increment allocs.
  - Else error 3.
  - On success, size:=0, allocated bit:=1, in_use+1, rsp_data=handle.
- FREE: allocated bit:=0; push the handle on the freed stack; in_use-1; rsp_data=0. Freeing a freed array gives error 4, so the freed stack never exceeds NArrays.
- PUSH:
  - size==NArea gives error 1.
  - Otherwise heap[array*NArea+size]:=cmd_data, size+1, rsp_data=new size.
- POP:
  - size==0 gives error 2.
  - Otherwise size-1, rsp_data=heap[array*NArea+new size].
- READ: cmd_index>=size gives error 5; otherwise rsp_data=element.
- WRITE:
  - cmd_index>=NArea gives error 5.
  - Otherwise store the element; if cmd_index>=size then size:=cmd_index+1. Elements between the old size and cmd_index are undefined.
  - rsp_data=size after the write.
- SIZE: rsp_data=size.
- Op 7 gives error 6.
- All address arithmetic is unsigned and at least clog2(NArrays*NArea)+1 bits wide; no wrap-around is permitted.
- Reset asserted mid-command: the command is abandoned, the response is suppressed and the engine returns to the reset state immediately.

Optional Feature:
- Macro ARRAY_HEAP_STATS_EN.
- Defined:
  - Adds outputs stat_peak (MemoryElementWidth): high-water mark of in_use.
  - Adds stat_errors (16 bits): count of responses with rsp_error!=0, saturating at 16'hFFFF.
  - Both are cleared by reset and update in the RESP cycle.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then ALLOC -> rsp_data=0, error 0, in_use=1. PUSH 1, PUSH 2, POP, POP -> rsp_data 1,2,2,1; then POP -> error 2, size stays 0.
- ALLOC 4 times, then ALLOC again -> handles 0,1,2,3, fifth gives error 3. FREE 2 then ALLOC -> handle 2, in_use=4.
- NArea=8: 8 PUSHes of values 10..17 -> ninth gives error 1. READ index 7 -> 17. READ index 8 -> error 5.
- WRITE index 5 value 9 to an empty array -> size 6. READ 5 -> 9. READ 6 -> error 5. SIZE -> 6.
- FREE handle 1 twice -> second gives error 4. PUSH to handle 9 -> error 4. op 7 -> error 6. Every failed command leaves in_use and sizes unchanged.
- reset_n low in the EXEC cycle of a PUSH -> no rsp_valid, in_use=0, cmd_ready=1 immediately. Back-to-back commands -> cmd_ready low exactly 2 cycles per command.
